// File: rtl/uart_tx_port.sv
// Byte-output port responder: buffers CPU writes in a small FIFO and sends
// each byte on a UART line as 8N1, LSB first, with w_busy as back-pressure.
module uart_tx_port #(
   parameter int CLK_PER_BIT = 4,
   parameter int DEPTH       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       w_req,
   input  logic [7:0] w_data,
   output logic       w_busy,
   output logic       txd,
   output logic       idle,
   output logic       overrun
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLK_PER_BIT);

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
   localparam logic [BAUD_W-1:0] BAUD_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};
   localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            state_q,   state_d;
   logic [BAUD_W-1:0] baud_q,    baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q,   shift_d;
   logic [CNT_W-1:0]  count_q,   count_d;
   logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
   logic              txd_q,     txd_d;
   logic              busy_q,    busy_d;
   logic              idle_q,    idle_d;
   logic              overrun_q, overrun_d;
   logic [7:0]        mem_q [DEPTH];

   logic              push_s;
   logic              pop_s;
   logic [7:0]        head_s;

   // Accept a write only when not full; a pop in the same cycle does not free the slot early.
   always_comb begin
      push_s    = w_req & ~busy_q;
      head_s    = mem_q[rd_ptr_q];
      overrun_d = overrun_q | (w_req & busy_q);
   end

   // Serializer sequencing: baud countdown, bit index and FIFO pops.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != CNT_ZERO) begin
               pop_s   = 1'b1;
               shift_d = head_s;
               baud_d  = BAUD_LOAD;
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (baud_q == BAUD_ZERO) begin
               state_d   = DATA;
               baud_d    = BAUD_LOAD;
               bit_idx_d = 3'd0;
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         DATA: begin
            if (baud_q == BAUD_ZERO) begin
               shift_d = {1'b0, shift_q[7:1]};
               baud_d  = BAUD_LOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         STOP: begin
            if (baud_q == BAUD_ZERO) begin
               // Chain straight into the next start bit so frames stay contiguous.
               if (count_q != CNT_ZERO) begin
                  pop_s   = 1'b1;
                  shift_d = head_s;
                  baud_d  = BAUD_LOAD;
                  state_d = START;
               end else begin
                  baud_d  = BAUD_ZERO;
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q - BAUD_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = BAUD_ZERO;
         end
      endcase
   end

   // FIFO occupancy, pointers and the registered status decodes.
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      busy_d = (count_d == CNT_FULL);
      idle_d = (state_d == IDLE) && (count_d == CNT_ZERO);
   end

   // Line level follows the state one cycle later, so txd comes straight from a flop.
   always_comb begin
      case (state_q)
         IDLE:    txd_d = 1'b1;
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_q[0];
         STOP:    txd_d = 1'b1;
         default: txd_d = 1'b1;
      endcase
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         baud_q    <= BAUD_ZERO;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         count_q   <= CNT_ZERO;
         wr_ptr_q  <= PTR_ZERO;
         rd_ptr_q  <= PTR_ZERO;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         idle_q    <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         idle_q    <= idle_d;
         overrun_q <= overrun_d;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= w_data;
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   assign w_busy  = busy_q;
   assign txd     = txd_q;
   assign idle    = idle_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a frame-schedule model predicts txd, w_busy, idle
// and overrun every cycle for a CLK_PER_BIT=4 and a CLK_PER_BIT=2 instance.
module tb_uart_tx_port;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       w_req;
   logic [7:0] w_data;
   logic       use2;
   logic       busy4, txd4, idle4, ovr4;
   logic       busy2, txd2, idle2, ovr2;

   always #5 clk = ~clk;

   uart_tx_port #(.CLK_PER_BIT(4), .DEPTH(DEPTH)) u_dut4 (
      .clk(clk), .reset(reset), .w_req(w_req & ~use2), .w_data(w_data),
      .w_busy(busy4), .txd(txd4), .idle(idle4), .overrun(ovr4));

   uart_tx_port #(.CLK_PER_BIT(2), .DEPTH(DEPTH)) u_dut2 (
      .clk(clk), .reset(reset), .w_req(w_req & use2), .w_data(w_data),
      .w_busy(busy2), .txd(txd2), .idle(idle2), .overrun(ovr2));

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int cur_c    = 4;
   int line_free;
   int rej_edge;
   int         acc_e[$];
   int         f_start[$];
   logic [7:0] f_data[$];

   // Model: every accepted byte gets a frame starting at max(accept+2, end of previous frame).
   function automatic int mcount(input int t);
      int cnt = 0;
      foreach (f_start[i]) begin
         if (acc_e[i] <= t) cnt++;
         if (f_start[i] - 1 <= t) cnt--;
      end
      return cnt;
   endfunction

   // Expected {txd, w_busy, idle, overrun} after clock edge t.
   function automatic logic [3:0] exp_vec(input int t);
      logic       tx = 1'b1;
      logic       st_idle = 1'b1;
      logic [7:0] d;
      int         b;
      int         cnt;
      cnt = mcount(t);
      foreach (f_start[i]) begin
         if (t >= f_start[i] && t < f_start[i] + 10 * cur_c) begin
            b = (t - f_start[i]) / cur_c;
            d = f_data[i];
            if (b == 0) tx = 1'b0;
            else if (b == 9) tx = 1'b1;
            else tx = d[b-1];
         end
         if (t >= f_start[i] - 1 && t < f_start[i] - 1 + 10 * cur_c) st_idle = 1'b0;
      end
      return {tx, (cnt == DEPTH), (st_idle && cnt == 0), (rej_edge >= 0 && rej_edge <= t)};
   endfunction

   function automatic logic [3:0] obs();
      return use2 ? {txd2, busy2, idle2, ovr2} : {txd4, busy4, idle4, ovr4};
   endfunction

   task automatic model_clear();
      acc_e.delete();
      f_start.delete();
      f_data.delete();
      line_free = 0;
      rej_edge  = -1;
      cyc       = 0;
   endtask

   task automatic tick(input logic req, input logic [7:0] data);
      int st;
      w_req  = req;
      w_data = data;
      @(posedge clk);
      cyc++;
      if (req) begin
         if (mcount(cyc - 1) < DEPTH) begin
            st = (cyc + 2 > line_free) ? cyc + 2 : line_free;
            acc_e.push_back(cyc);
            f_start.push_back(st);
            f_data.push_back(data);
            line_free = st + 10 * cur_c;
         end else if (rej_edge < 0) begin
            rej_edge = cyc;
         end
      end
      #1;
      w_req = 1'b0;
   endtask

   task automatic apply_reset(input int c);
      use2   = (c == 2);
      cur_c  = c;
      w_req  = 1'b0;
      w_data = 8'h00;
      reset  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset(4);
      reset = 1'b0;
      #2;
      n_checks++;
      if ({txd4, busy4, idle4, ovr4} !== 4'b1010)
         $display("FAIL reset_hold got=%b exp=%b", {txd4, busy4, idle4, ovr4}, 4'b1010);
      else n_pass++;
      apply_reset(4);
      repeat (6) begin
         tick(1'b0, 8'h00);
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
      end
   endtask

   task automatic test_single_byte();
      apply_reset(4);
      tick(1'b1, 8'h55);
      repeat (50) begin
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL single_55 cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
         tick(1'b0, 8'h00);
      end
      n_checks++;
      if ({idle4, ovr4} !== 2'b10) $display("FAIL single_end got=%b exp=%b", {idle4, ovr4}, 2'b10);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      apply_reset(4);
      for (int i = 0; i < 96; i++) begin
         if (i == 0) tick(1'b1, 8'hA3);
         else if (i == 4) tick(1'b1, 8'h0F);
         else tick(1'b0, 8'h00);
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
      end
   endtask

   task automatic test_overflow();
      apply_reset(4);
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 8'($urandom));
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL overflow_fill cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
      end
      n_checks++;
      if ({busy4, ovr4} !== 2'b11) $display("FAIL overflow_flags got=%b exp=%b", {busy4, ovr4}, 2'b11);
      else n_pass++;
      repeat (210) begin
         tick(1'b0, 8'h00);
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL overflow_drain cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame();
      apply_reset(4);
      for (int i = 0; i < 6; i++) tick(1'b1, 8'h00);
      while (cyc < f_start[0] + 12) begin
         tick(1'b0, 8'h00);
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL midreset_pre cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
      end
      #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({txd4, busy4, idle4, ovr4} !== 4'b1010)
         $display("FAIL midreset_async got=%b exp=%b", {txd4, busy4, idle4, ovr4}, 4'b1010);
      else n_pass++;
      apply_reset(4);
      tick(1'b1, 8'hFF);
      repeat (46) begin
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL midreset_post cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
         tick(1'b0, 8'h00);
      end
   endtask

   task automatic test_full_pop_push();
      apply_reset(4);
      for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h30 + i));
      while (cyc < f_start[1] - 2) begin
         tick(1'b0, 8'h00);
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL fullpop_wait cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
      end
      tick(1'b1, 8'hEE);
      n_checks++;
      if ({busy4, ovr4} !== 2'b01) $display("FAIL fullpop_flags got=%b exp=%b", {busy4, ovr4}, 2'b01);
      else n_pass++;
      repeat (170) begin
         tick(1'b0, 8'h00);
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL fullpop_drain cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
      end
   endtask

   task automatic test_wrap_fast();
      int sent = 0;
      apply_reset(2);
      while (sent < 16 || cyc < line_free + 3) begin
         if (sent < 16 && (cyc % 4) == 3 && mcount(cyc) < DEPTH) begin
            tick(1'b1, 8'(sent));
            sent++;
         end else begin
            tick(1'b0, 8'h00);
         end
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL wrap_cpb2 cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
      end
   endtask

   task automatic test_random_traffic();
      apply_reset(4);
      for (int i = 0; i < 460; i++) begin
         if (i < 400 && (cyc % 4) == 3 && $urandom_range(0, 1) == 1) tick(1'b1, 8'($urandom));
         else tick(1'b0, 8'h00);
         n_checks++;
         if (obs() !== exp_vec(cyc)) $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec(cyc));
         else n_pass++;
      end
   endtask

   initial begin
      reset  = 1'b0;
      w_req  = 1'b0;
      w_data = 8'h00;
      use2   = 1'b0;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
      test_full_pop_push();
      test_wrap_fast();
      test_random_traffic();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Responder for the CPU byte-output port (`w_req`/`w_data`/`w_busy`). Buffers bytes in a small FIFO and serializes each one onto a UART line, 8N1, LSB first.
- Sits between the CPU and the board TX pin.
- Drives `w_busy` as back-pressure. The CPU samples `w_busy` once per 4-cycle update slot and issues single-cycle `w_req` pulses only in that slot.

Parameters:
CLK_PER_BIT, 4, clock cycles per UART bit (≥2)
DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
w_req  input  1  single-cycle write request from CPU
w_data  input  8  byte to send; valid when w_req=1
w_busy  output  1  FIFO full; a request in this state is dropped
txd  output  1  serial line; idles high
idle  output  1  1 when FIFO empty and state is IDLE
overrun  output  1  sticky: a w_req arrived while w_busy=1

Behaviour:
- Reset (reset=0, asynchronous): txd=1, w_busy=0, idle=1, overrun=0, FIFO count=0, pointers=0, state=IDLE, baud counter=0.
  - Reset mid-frame aborts the frame; txd goes to 1 immediately.
- FIFO:
  - count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - w_busy = (count==DEPTH), a registered-state decode with no combinational path from w_req.
  - Push when w_req=1 and w_busy=0.
  - When w_req=1 and w_busy=1: data is dropped, overrun is set at the next edge, and it stays set until reset.
  - Pop (by the FSM) and push may occur in the same cycle; count is unchanged.
  - A push while full is rejected even if a pop happens in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
  - Baud counter loads CLK_PER_BIT-1 on entry to each bit and decrements each cycle. The bit ends when the counter is 0.
  - IDLE: txd=1. If count>0, pop the head into an 8-bit shift register and go to START.
  - START: txd=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd = shift[0]. At bit end, shift right; after the 8th bit go to STOP.
  - STOP: txd=1 for CLK_PER_BIT cycles. At bit end, if count>0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Latency:
  - For a byte accepted at edge k into an empty FIFO with the FSM in IDLE: pop at edge k+1, txd=0 from edge k+2.
  - Frame length is exactly 10*CLK_PER_BIT cycles. Back-to-back frames are contiguous.
- txd is driven from a register (glitch-free).
- idle = (state==IDLE) && (count==0), registered-state decode.

Test Plan:
1. CLK_PER_BIT=4, single w_req with w_data=0x55 → txd low 4 cycles starting 2 cycles after the accepting edge, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles; idle returns to 1; overrun=0.
2. Push 0xA3 then 0x0F in consecutive update slots → two contiguous 40-cycle frames with no idle gap. Bits LSB first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
3. DEPTH=4, push 6 bytes back-to-back while the first frame is in progress → w_busy=1 after the count reaches 4. The extra request is dropped and overrun=1. The 5 accepted bytes are transmitted in order.
4. Assert reset=0 mid-DATA of a 0x00 frame → txd=1, w_busy=0, idle=1, overrun=0 immediately. After release, push 0xFF → a clean frame (start 0, eight 1s, stop 1).
5. FIFO full with a pop and a w_req in the same cycle → the push is rejected, overrun=1, count decrements by 1.
6. CLK_PER_BIT=2, 16 sequential bytes 0x00..0x0F → serial output matches in order, and pointers wrap correctly past DEPTH.
